// File: rtl/di_pkg.sv
// rtl/di_pkg.sv - shared DI bus widths, ready lookahead and status register layout
package di_pkg;

  localparam int DI_ADDR_W          = 16;
  localparam int DI_DATA_W          = 16;

  // Reads the host may still issue after rdwr_ready drops
  localparam int DI_READY_LOOKAHEAD = 3;

  // Status register layout: {overflow, underflow, 9'b0, level[4:0]}
  localparam int STAT_OVF_BIT       = 15;
  localparam int STAT_UNF_BIT       = 14;
  localparam int STAT_LVL_W         = 5;

  function automatic logic [DI_DATA_W-1:0] status_word(input logic ovf,
                                                        input logic unf,
                                                        input logic [STAT_LVL_W-1:0] lvl);
    logic [DI_DATA_W-1:0] w;
    w                   = '0;
    w[STAT_OVF_BIT]     = ovf;
    w[STAT_UNF_BIT]     = unf;
    w[STAT_LVL_W-1:0]   = lvl;
    return w;
  endfunction

endpackage

// File: rtl/di_fifo_mem.sv
// rtl/di_fifo_mem.sv - FIFO storage, one write port and one registered read port
module di_fifo_mem
  import di_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  rd_clr,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DI_DATA_W-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DI_DATA_W-1:0]  rd_data
);

  logic [DI_DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Array write; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds the last popped word until the next pop or a clear
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/di_read_fifo.sv
// rtl/di_read_fifo.sv - DI read FIFO endpoint; status register enabled by DI_READ_FIFO_STATUS_EN
module di_read_fifo
  import di_pkg::*;
#(
  parameter logic [DI_ADDR_W-1:0] EP_ADDR    = 16'h0000,
  parameter logic [DI_ADDR_W-1:0] REG_ADDR   = 16'h0000,
  parameter int                   DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [DI_ADDR_W-1:0]  diEpAddr,
  input  logic [DI_ADDR_W-1:0]  diRegAddr,
  input  logic                  diRead,
  input  logic                  diWrite,
  input  logic [DI_DATA_W-1:0]  diRegDataIn,
  input  logic                  diReset,
  output logic [DI_DATA_W-1:0]  diRegDataOut,
  output logic                  rdwr_ready,
  input  logic                  wr_en,
  input  logic [DI_DATA_W-1:0]  wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  sel;
  logic                  sel_q;
  logic                  pop;
  logic                  push;
  logic                  underflow_rd;
  logic                  rdy_next;
  logic [DEPTH_LOG2:0]   level_next;
  logic [DI_DATA_W-1:0]  mem_rd_data;
  logic                  unused_inputs;

  // Host write data is never consumed; the FIFO register is read-only
  assign unused_inputs = ^{diWrite, diRegDataIn};

  assign sel          = (diEpAddr == EP_ADDR) && (diRegAddr == REG_ADDR);
  assign full         = (level == FULL_LVL);
  assign pop          = sel && diRead && (level != '0) && !diReset;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle
  assign push         = wr_en && !diReset && (!full || pop);
  assign underflow_rd = sel && diRead && (level == '0) && !diReset;

`ifdef DI_READ_FIFO_STATUS_EN
  logic                 sel_st;
  logic                 sel_st_q;
  logic                 ovf;
  logic                 unf;
  logic [DI_DATA_W-1:0] stat_q;

  assign sel_st = (diEpAddr == EP_ADDR) && (diRegAddr == REG_ADDR + 16'd1);
`endif

  // Occupancy after this cycle's push and pop
  always_comb begin
    level_next = level;
    if (diReset) level_next = '0;
    else         level_next = level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  end

  // Ready prediction; needs one cycle of selection before it is trusted
  always_comb begin
    rdy_next = 1'b0;
    if (!diReset) begin
      if (sel && sel_q && (int'(level_next) >= DI_READY_LOOKAHEAD)) rdy_next = 1'b1;
`ifdef DI_READ_FIFO_STATUS_EN
      if (sel_st) rdy_next = 1'b1;
`endif
    end
  end

  // Pointers, occupancy, selection history and ready register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      sel_q      <= 1'b0;
      rdwr_ready <= 1'b0;
    end else begin
      level      <= level_next;
      sel_q      <= sel;
      rdwr_ready <= rdy_next;
      if (diReset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

  di_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .resetb  (resetb),
    .rd_clr  (diReset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

`ifdef DI_READ_FIFO_STATUS_EN
  // Sticky flags and the status snapshot presented one cycle later
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      sel_st_q <= 1'b0;
      stat_q   <= '0;
    end else begin
      sel_st_q <= sel_st;
      stat_q   <= diReset ? '0 : status_word(ovf, unf, STAT_LVL_W'(level));
      if (sel_st && diWrite) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (wr_en && !diReset && !push) ovf <= 1'b1;
        if (underflow_rd)               unf <= 1'b1;
      end
    end
  end

  assign diRegDataOut = sel_q ? mem_rd_data : (sel_st_q ? stat_q : '0);
`else
  assign diRegDataOut = sel_q ? mem_rd_data : '0;
`endif

endmodule
